// File: rtl/im_lsu.sv
// im_lsu: memory-stage load/store unit.
// Issues byte/half/word accesses on a valid/ready data bus, extends load
// data into ReadDataM and holds stallM while an access is in flight.
// The IE/IM register is frozen while stallM is high, so the request fields
// are driven straight from the IM-stage inputs and stay stable in REQ/WAIT.
//
//   state | meaning
//   IDLE  | no access outstanding; an aligned op issues its request here
//   REQ   | request presented but not yet accepted
//   WAIT  | load accepted, waiting for read data (watchdog running)
//   DONE  | access finished, stall released for one cycle
module im_lsu #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flushM,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       RD2M,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        funct3M,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [3:0]        dmem_wstrb,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       ReadDataM,
  output logic              stallM,
  output logic              misalignM,
  output logic              buserrM
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        disc_q, disc_d;
  logic        buserr_q, buserr_d;

  logic        is_load, is_store, op, load_op;
  logic        sz_byte, sz_half, sz_word;
  logic        misalign_raw, go, accept;
  logic [1:0]  a_lo;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        ld_signed, discarding, wd_expired;

  assign a_lo     = ALUResultM[1:0];
  assign is_load  = (ResultSrcM == 2'b01);
  assign is_store = MemWriteM;
  assign op       = is_load | is_store;
  // A request flagged as both load and store is handled as a store.
  assign load_op  = is_load & ~is_store;

  // funct3[1:0]: 00 byte, 01 half, anything else is a full word.
  assign sz_byte   = (funct3M[1:0] == 2'b00);
  assign sz_half   = (funct3M[1:0] == 2'b01);
  assign sz_word   = ~sz_byte & ~sz_half;
  assign ld_signed = ~funct3M[2];

  assign misalign_raw = (sz_half & a_lo[0]) | (sz_word & (a_lo != 2'b00));
  assign misalignM    = op & misalign_raw;
  assign go           = op & ~misalign_raw;

  // Reset gates the request so nothing leaks onto the bus while it is held.
  assign dmem_req_valid = ~reset & (((state_q == S_IDLE) & go & ~flushM) | (state_q == S_REQ));
  assign stallM         = dmem_req_valid | (~reset & (state_q == S_WAIT));
  assign accept         = dmem_req_valid & dmem_req_ready;

  assign dmem_addr  = {ALUResultM[ADDR_W-1:2], 2'b00};
  assign dmem_we    = dmem_req_valid & is_store;
  assign dmem_wstrb = (dmem_req_valid & is_store) ? st_strb : 4'b0000;
  assign dmem_wdata = st_wdata;

  assign ReadDataM = rdata_q;
  assign buserrM   = buserr_q;

  // Store lane replication and byte enables.
  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = RD2M;
    if (sz_byte) begin
      st_strb  = 4'b0001 << a_lo;
      st_wdata = {4{RD2M[7:0]}};
    end else if (sz_half) begin
      st_strb  = a_lo[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{RD2M[15:0]}};
    end
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (a_lo)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = a_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    if (sz_byte) begin
      ld_ext = {{24{ld_signed & ld_byte[7]}}, ld_byte};
    end else if (sz_half) begin
      ld_ext = {{16{ld_signed & ld_half[15]}}, ld_half};
    end else begin
      ld_ext = dmem_rdata;
    end
  end

  assign discarding = disc_q | flushM;
  assign wd_expired = (TO_LIMIT != 32'd0) && ((wd_cnt_q + 32'd1) == TO_LIMIT);

  // Next-state logic for the access sequencer, watchdog and discard tracking.
  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    wd_cnt_d = wd_cnt_q;
    disc_d   = disc_q;
    buserr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        wd_cnt_d = 32'd0;
        disc_d   = 1'b0;
        if (accept) begin
          state_d = load_op ? S_WAIT : S_DONE;
        end else if (dmem_req_valid) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        wd_cnt_d = 32'd0;
        if (accept) begin
          // An accepted load must still be drained even when flushed.
          if (flushM) begin
            state_d = load_op ? S_WAIT : S_IDLE;
            disc_d  = load_op;
          end else begin
            state_d = load_op ? S_WAIT : S_DONE;
          end
        end else if (flushM) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        wd_cnt_d = wd_cnt_q + 32'd1;
        if (flushM) begin
          disc_d = 1'b1;
        end
        if (dmem_rsp_valid) begin
          if (discarding) begin
            state_d = S_IDLE;
          end else begin
            rdata_d = ld_ext;
            state_d = S_DONE;
          end
        end else if (wd_expired) begin
          if (discarding) begin
            state_d = S_IDLE;
          end else begin
            rdata_d  = 32'd0;
            buserr_d = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rdata_q  <= 32'd0;
      wd_cnt_q <= 32'd0;
      disc_q   <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      wd_cnt_q <= wd_cnt_d;
      disc_q   <= disc_d;
      buserr_q <= buserr_d;
    end
  end

endmodule

// File: doc/im_lsu.md
Name: im_lsu

Overview:
- Memory-stage load/store unit. Sits directly downstream of the IE/IM pipeline register and consumes its ALUResultM, RD2M, MemWriteM, ResultSrcM and funct3M outputs.
- Performs byte, half and word accesses on a valid/ready data-memory bus and returns sign- or zero-extended load data to the IM/IW register.
- Asserts stallM while an access is outstanding. The hazard unit freezes all upstream stages, including IE/IM, while stallM is high.

Parameters:
- ADDR_W, 32, data-bus address width (ALUResultM[ADDR_W-1:0] used).
- TIMEOUT, 255, max cycles in WAIT before bus error; 0 disables watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flushM  in  1  kill the instruction currently in IM.
- ALUResultM  in  32  effective address.
- RD2M  in  32  store data.
- MemWriteM  in  1  store request.
- ResultSrcM  in  2  2'b01 = load.
- funct3M  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  request accepted when valid&ready.
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- dmem_we  out  1  1 = write.
- dmem_wstrb  out  4  byte-lane enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rsp_valid  in  1  read data valid.
- dmem_rdata  in  32  read word.
- ReadDataM  out  32  extended load result (registered).
- stallM  out  1  pipeline stall request.
- misalignM  out  1  misaligned access flag.
- buserrM  out  1  one-cycle pulse on watchdog timeout.

Behaviour:
- Operation present: op = (ResultSrcM==2'b01) | MemWriteM. If both are set, the op is treated as a store.
- Misaligned: h/hu with addr[0]=1, or w with addr[1:0]!=0.
  - misalignM is combinational.
  - No bus request is issued and stallM=0. Handling belongs to the trap logic.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, op & aligned & !flushM:
  - dmem_req_valid=1 and stallM=1, both combinational.
  - If dmem_req_ready: load → WAIT, store → DONE. Otherwise → REQ.
- REQ:
  - Hold dmem_req_valid=1 with the same addr/we/wstrb/wdata; stallM=1.
  - On ready → WAIT (load) or DONE (store).
  - flushM → IDLE, request withdrawn.
- WAIT:
  - stallM=1; dmem_rsp_valid is sampled only in this state, earliest one cycle after acceptance.
  - On rsp_valid: ReadDataM <= extended data → DONE.
  - Watchdog counter increments each WAIT cycle; reaching TIMEOUT pulses buserrM, sets ReadDataM=0, → DONE.
  - flushM in WAIT sets a discard flag. On the response, ReadDataM is not updated → IDLE.
- DONE: stallM=0, so the pipeline advances this cycle → IDLE.
- Latency: store stalls 1 cycle minimum; load stalls 2 cycles minimum (accept in IDLE, response in WAIT, DONE).
- Load extension uses addr[1:0]:
  - b: sign-extend byte lane addr[1:0]; bu: zero-extend it.
  - h: sign-extend halfword lane addr[1]; hu: zero-extend it.
  - w: whole word.
  - Unlisted funct3 values are treated as w.
- Store lanes:
  - sb: wdata={4{RD2M[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - sh: wdata={2{RD2M[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - sw: wstrb=4'b1111.
- dmem_we=0 and dmem_wstrb=0 for loads, and whenever dmem_req_valid=0.
- Reset values:
  - State IDLE; ReadDataM=0; watchdog count and discard flag cleared.
  - dmem_req_valid, stallM, buserrM = 0.
  - Reset mid-transaction abandons the access; any late response is ignored because the FSM is not in WAIT.
- Simultaneous flushM and ready in IDLE/REQ: flush wins, and the accepted request is tracked as discarded (load → WAIT with discard, store → IDLE).

Test Plan:
- Load word, addr 0x100, ready=1, rsp 1 cycle later with 0x80FF_1234 → stallM high 2 cycles, ReadDataM=0x80FF_1234, dmem_addr=0x100.
- lb addr 0x103 with rdata 0x80FF_1234 → ReadDataM=0xFFFF_FF80. lbu at the same address → 0x0000_0080. lhu addr 0x102 → 0x0000_80FF.
- sb addr 0x201, RD2M=0xDEAD_BEEF, ready delayed 3 cycles → req_valid held 4 cycles with wdata=0xEFEF_EFEF, wstrb=0010; stallM drops in DONE.
- lw addr 0x102 → misalignM=1, no dmem_req_valid, stallM=0.
- Load accepted, flushM in WAIT, rsp later with 0xAAAA_AAAA → ReadDataM unchanged, FSM returns to IDLE.
- TIMEOUT=4, load accepted, no response → buserrM pulses after 4 WAIT cycles, ReadDataM=0, stallM released next cycle. Separately: reset asserted in REQ → all outputs 0 next cycle.
